// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bundles for the shared data-memory arbiter.
// master drives the access, slave accepts it and returns grant/response.
interface dmem_req_if #(parameter int AW = 32);
    logic          req;
    logic [3:0]    we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;

    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

interface dmem_mem_if #(parameter int AW = 32);
    logic          en;
    logic [3:0]    we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;

    modport master (output en, we, addr, wdata, input  rdata);
    modport slave  (input  en, we, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-ported data memory (core port m0, loader/debug m1).
// Round-robin or fixed-priority grant; a MEM_LAT-deep tag pipeline routes read data back.
module dmem_arbiter #(
    parameter int AW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset,
    dmem_req_if.slave  m0,
    dmem_req_if.slave  m1,
    dmem_mem_if.master mem
);

    logic          both_req;
    logic          any_req;
    logic          win1;
    logic [3:0]    we_mux;
    logic [AW-1:0] addr_mux;
    logic [31:0]   wdata_mux;
    logic          rd_issue;
    logic          rsp_vld;
    logic          rsp_id;

    logic               rr_q, rr_d;
    logic [MEM_LAT:1]   vld_pipe_q, vld_pipe_d;
    logic [MEM_LAT:1]   id_pipe_q, id_pipe_d;

    // Every output is gated by reset so nothing leaks while it is held low.
    always_comb begin
        both_req = m0.req & m1.req;
        any_req  = reset & (m0.req | m1.req);
        if (both_req) win1 = (FIXED_PRIO != 0) ? 1'b0 : rr_q;
        else          win1 = m1.req;
    end

    always_comb begin
        we_mux    = win1 ? m1.we    : m0.we;
        addr_mux  = win1 ? m1.addr  : m0.addr;
        wdata_mux = win1 ? m1.wdata : m0.wdata;

        m0.gnt    = any_req & ~win1;
        m1.gnt    = any_req &  win1;
        mem.en    = any_req;
        mem.we    = any_req ? we_mux    : 4'b0000;
        mem.addr  = any_req ? addr_mux  : '0;
        mem.wdata = any_req ? wdata_mux : 32'h0;
        rd_issue  = any_req & (we_mux == 4'b0000);
    end

    // The pointer moves to the loser only when both contended.
    always_comb begin
        rr_d = rr_q;
        if (any_req && both_req && (FIXED_PRIO == 0)) rr_d = ~win1;
    end

    always_comb begin
        vld_pipe_d = '0;
        id_pipe_d  = '0;
        for (int i = MEM_LAT; i > 1; i--) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            id_pipe_d[i]  = id_pipe_q[i-1];
        end
        vld_pipe_d[1] = rd_issue;
        id_pipe_d[1]  = win1;
    end

    always_comb begin
        rsp_vld   = vld_pipe_q[MEM_LAT];
        rsp_id    = id_pipe_q[MEM_LAT];
        m0.rvalid = rsp_vld & ~rsp_id;
        m1.rvalid = rsp_vld &  rsp_id;
        m0.rdata  = m0.rvalid ? mem.rdata : 32'h0;
        m1.rdata  = m1.rvalid ? mem.rdata : 32'h0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q       <= 1'b0;
            vld_pipe_q <= '0;
            id_pipe_q  <= '0;
        end else begin
            rr_q       <= rr_d;
            vld_pipe_q <= vld_pipe_d;
            id_pipe_q  <= id_pipe_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances cover RR/LAT1, fixed-priority/LAT1, RR/LAT3.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    dmem_req_if #(.AW(32)) a0 (), a1 (), b0 (), b1 (), c0 (), c1 ();
    dmem_mem_if #(.AW(32)) am (), bm (), cm ();

    dmem_arbiter #(.AW(32), .MEM_LAT(1), .FIXED_PRIO(0)) u_a (
        .clk(clk), .reset(reset), .m0(a0), .m1(a1), .mem(am));
    dmem_arbiter #(.AW(32), .MEM_LAT(1), .FIXED_PRIO(1)) u_b (
        .clk(clk), .reset(reset), .m0(b0), .m1(b1), .mem(bm));
    dmem_arbiter #(.AW(32), .MEM_LAT(3), .FIXED_PRIO(0)) u_c (
        .clk(clk), .reset(reset), .m0(c0), .m1(c1), .mem(cm));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        a0.req = 1'b0; a1.req = 1'b0;
        b0.req = 1'b0; b1.req = 1'b0;
        c0.req = 1'b0; c1.req = 1'b0;
        a0.we = 4'h0; a1.we = 4'h0; b0.we = 4'h0; b1.we = 4'h0; c0.we = 4'h0; c1.we = 4'h0;
    endtask

    logic [3:0] rr_exp_m1;

    initial begin
        a0.addr = 32'h100; a0.wdata = 32'h55; a1.addr = 32'h200; a1.wdata = 32'h66;
        b0.addr = 32'h100; b0.wdata = 32'h0;  b1.addr = 32'h200; b1.wdata = 32'h0;
        c0.addr = 32'h80;  c0.wdata = 32'h0;  c1.addr = 32'h90;  c1.wdata = 32'h0;
        idle_all();
        am.rdata = 32'hFFFF_FFFF; bm.rdata = 32'h0; cm.rdata = 32'hFFFF_FFFF;

        // Reset held with both requesting: everything quiet.
        a0.req = 1'b1; a1.req = 1'b1; b0.req = 1'b1; b1.req = 1'b1; c0.req = 1'b1; c1.req = 1'b1;
        a0.we = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a0_gnt",   {31'b0, a0.gnt},    32'h0);
        chk("rst_a1_gnt",   {31'b0, a1.gnt},    32'h0);
        chk("rst_mem_en",   {31'b0, am.en},     32'h0);
        chk("rst_mem_we",   {28'b0, am.we},     32'h0);
        chk("rst_mem_addr", am.addr,            32'h0);
        chk("rst_mem_wdat", am.wdata,           32'h0);
        chk("rst_a0_rvld",  {31'b0, a0.rvalid}, 32'h0);
        chk("rst_a0_rdata", a0.rdata,           32'h0);
        chk("rst_a1_rdata", a1.rdata,           32'h0);
        chk("rst_c0_rdata", c0.rdata,           32'h0);

        // Release: m0 favoured on the first cycle; drop requests before the edge.
        reset = 1'b1;
        #1;
        chk("rel_a0_gnt", {31'b0, a0.gnt}, 32'h1);
        chk("rel_a1_gnt", {31'b0, a1.gnt}, 32'h0);
        chk("rel_b0_gnt", {31'b0, b0.gnt}, 32'h1);
        chk("rel_c0_gnt", {31'b0, c0.gnt}, 32'h1);
        idle_all();
        #1;
        chk("idle_mem_en", {31'b0, am.en}, 32'h0);
        chk("idle_mem_we", {28'b0, am.we}, 32'h0);

        // Single m0 read, MEM_LAT=1.
        @(negedge clk);
        a0.req = 1'b1; a0.addr = 32'h10;
        #1;
        chk("rd_a0_gnt",   {31'b0, a0.gnt}, 32'h1);
        chk("rd_mem_en",   {31'b0, am.en},  32'h1);
        chk("rd_mem_addr", am.addr,         32'h10);
        chk("rd_mem_we",   {28'b0, am.we},  32'h0);
        @(negedge clk);
        a0.req = 1'b0; am.rdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_a0_rvld",  {31'b0, a0.rvalid}, 32'h1);
        chk("rd_a0_rdata", a0.rdata,           32'hDEAD_BEEF);
        chk("rd_a1_rvld",  {31'b0, a1.rvalid}, 32'h0);
        chk("rd_a1_rdata", a1.rdata,           32'h0);
        @(negedge clk);
        am.rdata = 32'h1234_5678;
        #1;
        chk("rd_a0_rvld_once", {31'b0, a0.rvalid}, 32'h0);
        chk("rd_ignore_rdata", a0.rdata,           32'h0);

        // Round-robin contention: grants m0,m1,m0,m1, responses one cycle behind.
        rr_exp_m1 = 4'b1010;
        a0.addr = 32'h100; a1.addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a0.req = (i < 4); a1.req = (i < 4);
            am.rdata = 32'hA000_0000 + i;
            #1;
            if (i < 4) begin
                chk($sformatf("rr_a0_gnt%0d", i), {31'b0, a0.gnt}, {31'b0, ~rr_exp_m1[i]});
                chk($sformatf("rr_a1_gnt%0d", i), {31'b0, a1.gnt}, {31'b0,  rr_exp_m1[i]});
                chk($sformatf("rr_addr%0d", i), am.addr, rr_exp_m1[i] ? 32'h200 : 32'h100);
            end
            if (i > 0) begin
                chk($sformatf("rr_a0_rvld%0d", i), {31'b0, a0.rvalid}, {31'b0, ~rr_exp_m1[i-1]});
                chk($sformatf("rr_a1_rvld%0d", i), {31'b0, a1.rvalid}, {31'b0,  rr_exp_m1[i-1]});
                chk($sformatf("rr_rdata%0d", i),
                    rr_exp_m1[i-1] ? a1.rdata : a0.rdata, 32'hA000_0000 + i);
            end
        end

        // m1 write: passthrough, no response.
        @(negedge clk);
        a0.req = 1'b0;
        a1.req = 1'b1; a1.we = 4'b0011; a1.addr = 32'h40; a1.wdata = 32'h0000_ABCD;
        #1;
        chk("wr_a1_gnt",   {31'b0, a1.gnt}, 32'h1);
        chk("wr_mem_we",   {28'b0, am.we},  32'h3);
        chk("wr_mem_addr", am.addr,         32'h40);
        chk("wr_mem_wdat", am.wdata,        32'h0000_ABCD);
        @(negedge clk);
        a1.req = 1'b0; a1.we = 4'h0; am.rdata = 32'hFFFF_FFFF;
        #1;
        chk("wr_a1_no_rvld", {31'b0, a1.rvalid}, 32'h0);
        chk("wr_a1_rdata",   a1.rdata,           32'h0);

        // Single grant left rr at m0; contention then flips it to m1.
        a0.req = 1'b1; a1.req = 1'b1;
        #1;
        chk("rr_keep_a0", {31'b0, a0.gnt}, 32'h1);
        @(negedge clk);
        #1;
        chk("rr_flip_a1", {31'b0, a1.gnt}, 32'h1);
        idle_all();

        // Fixed priority: m0 always wins, m1 gets in once m0 drops.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b0.req = 1'b1; b1.req = 1'b1;
            #1;
            chk($sformatf("fp_b0_gnt%0d", i), {31'b0, b0.gnt}, 32'h1);
            chk($sformatf("fp_b1_gnt%0d", i), {31'b0, b1.gnt}, 32'h0);
            if (i > 0) chk($sformatf("fp_b0_rvld%0d", i), {31'b0, b0.rvalid}, 32'h1);
        end
        @(negedge clk);
        b0.req = 1'b0;
        #1;
        chk("fp_b1_gnt_after", {31'b0, b1.gnt}, 32'h1);
        chk("fp_b0_gnt_after", {31'b0, b0.gnt}, 32'h0);
        idle_all();

        // MEM_LAT=3: response lands exactly three cycles after the grant.
        @(negedge clk);
        c0.req = 1'b1; c0.addr = 32'h80;
        #1;
        chk("l3_c0_gnt", {31'b0, c0.gnt}, 32'h1);
        @(negedge clk);
        c0.req = 1'b0;
        #1;
        chk("l3_rvld_t1", {31'b0, c0.rvalid}, 32'h0);
        @(negedge clk);
        #1;
        chk("l3_rvld_t2", {31'b0, c0.rvalid}, 32'h0);
        @(negedge clk);
        cm.rdata = 32'hCAFE_0003;
        #1;
        chk("l3_rvld_t3",  {31'b0, c0.rvalid}, 32'h1);
        chk("l3_rdata_t3", c0.rdata,           32'hCAFE_0003);
        @(negedge clk);
        #1;
        chk("l3_rvld_t4", {31'b0, c0.rvalid}, 32'h0);

        // Reset mid-flight drops the outstanding read.
        @(negedge clk);
        c0.req = 1'b1;
        #1;
        chk("rmf_c0_gnt", {31'b0, c0.gnt}, 32'h1);
        @(negedge clk);
        c0.req = 1'b0;
        reset = 1'b0;
        #1;
        chk("rmf_rvld_in_rst", {31'b0, c0.rvalid}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rmf_rvld_t2", {31'b0, c0.rvalid}, 32'h0);
        @(negedge clk);
        #1;
        chk("rmf_rvld_t3", {31'b0, c0.rvalid}, 32'h0);
        chk("rmf_rdata_t3", c0.rdata,          32'h0);
        @(negedge clk);
        #1;
        chk("rmf_rvld_t4", {31'b0, c0.rvalid}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported data memory between two requesters: m0, the core load/store port, and m1, the program-loader/debug port.
- Arbitrates each cycle, either round-robin or fixed-priority. Drives the memory port and tracks in-flight reads through a MEM_LAT-deep tag pipeline, so each read response is routed back to its originator.
- Sits between the core's data-access logic and the dmem instance.

Parameters:
- AW, 32, address width of requester and memory address ports
- MEM_LAT, 1, memory read latency in cycles (legal range 1..4)
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- m0_req  in  1  m0 access request, held until granted
- m0_we  in  4  m0 byte write enables; 4'b0000 = read
- m0_addr  in  AW  m0 byte address
- m0_wdata  in  32  m0 write data
- m0_gnt  out  1  m0 request accepted this cycle
- m0_rvalid  out  1  m0 read data valid
- m0_rdata  out  32  m0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0, for requester m1
- mem_en  out  1  memory access strobe
- mem_we  out  4  memory byte write enables
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after a read strobe

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears the tag pipeline and sets the round-robin pointer rr=0 (m0 favoured).
  - All outputs are 0 while reset=0: gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, rdata.
- Arbitration (combinational, same cycle as req):
  - If only one requester asserts req, it wins.
  - If both assert req and FIXED_PRIO=1, m0 wins.
  - If both assert req and FIXED_PRIO=0, the winner is the requester rr points to. After that grant, rr points to the loser.
  - rr updates only on cycles where both requested. A single-requester grant leaves rr unchanged.
- Grant:
  - The winner's gnt=1 for that cycle.
  - mem_en=1, and mem_we/mem_addr/mem_wdata are muxed from the winner in the same cycle.
  - If no requester asserts req: mem_en=0, mem_we=0.
  - The loser sees gnt=0 and must hold req, we, addr and wdata stable.
  - A grant is one accepted access. A requester with req held high gets one grant per won cycle, so back-to-back issue every cycle is allowed.
- Tag pipeline:
  - Each cycle, a stage-0 entry {valid = mem_en & (mem_we==0), id = winner} shifts into a MEM_LAT-deep register chain.
  - At the output stage, if valid: that id's rvalid=1 and its rdata=mem_rdata (combinational passthrough). The other requester's rdata is 0.
  - rvalid is exactly one cycle per granted read, at cycle T+MEM_LAT for a grant at cycle T.
  - Writes produce no rvalid; a write completes at its grant.
- Ordering: responses return in grant order. Interleaved m0/m1 reads are supported with one read in flight per cycle slot.
- Reset asserted mid-operation drops in-flight responses; no rvalid is produced for them after reset releases.
- mem_rdata is ignored on cycles where the output stage is invalid.
- Responses need no back-pressure; requesters must accept rvalid unconditionally.
- Width rules:
  - we, wdata and addr pass through unmodified. No byte-lane shifting; requesters pre-replicate store data.
  - Address alignment is the requester's responsibility.

Test Plan:
- Reset: hold reset=0 with m0_req=m1_req=1 -> all outputs 0. Release reset -> m0_gnt=1 in the first cycle.
- Single read, MEM_LAT=1: m0 reads addr 0x10 at cycle T, memory returns 0xDEADBEEF -> mem_en=1, mem_addr=0x10 at T; m0_rvalid=1, m0_rdata=0xDEADBEEF at T+1; m1_rvalid stays 0.
- Round-robin contention, FIXED_PRIO=0: both requesters hold req reading 0x100/0x200 for 4 cycles -> grants alternate m0,m1,m0,m1; rvalid alternates m0,m1,m0,m1 starting at T+MEM_LAT with matching data.
- Fixed priority, FIXED_PRIO=1: both requesters hold req for 3 cycles -> m0_gnt=1 each cycle, m1_gnt=0. m0 drops req -> m1_gnt=1 the next cycle.
- Write ack: m1 writes we=4'b0011, addr 0x40, wdata 0x0000ABCD -> mem_we=4'b0011, mem_wdata=0x0000ABCD in the grant cycle; no m1_rvalid follows.
- Reset mid-flight, MEM_LAT=3: grant m0 read at T, assert reset at T+1, release at T+2 -> no m0_rvalid at T+3.
